// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
// Provides the RVC quadrant test used by the aligner.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int HALF_W = 16;
  localparam logic [1:0] OPC_32B = 2'b11;

  function automatic logic is_rvc(
    input logic [HALF_W-1:0] half
  );
    return half[1:0] != OPC_32B;
  endfunction

endpackage

// File: rtl/instr_aligner.sv
// Combinational RV32IC extractor: word + held halfword -> instruction.
// Ports: word/hold/hold_valid/pc_half in; instr, flags, next hold, pc step out.
module instr_aligner
  import instr_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0]   word,
  input  logic [HALF_W-1:0] hold,
  input  logic              hold_valid,
  input  logic              pc_half,
  output logic [XLEN-1:0]   instr,
  output logic              is_compressed,
  output logic              valid,
  output logic              consume_word,
  output logic [HALF_W-1:0] next_hold,
  output logic              next_hold_valid,
  output logic [1:0]        pc_incr
);

  logic lo_rvc;
  logic hi_rvc;
  logic hold_rvc;

  assign lo_rvc   = is_rvc(word[15:0]);
  assign hi_rvc   = is_rvc(word[31:16]);
  assign hold_rvc = is_rvc(hold);

  // pc_incr counts halfwords; 0 means a bubble
  always_comb begin
    instr           = '0;
    is_compressed   = 1'b0;
    valid           = 1'b0;
    consume_word    = 1'b0;
    next_hold       = hold;
    next_hold_valid = 1'b0;
    pc_incr         = 2'd0;
    unique case (1'b1)
      hold_valid: begin
        valid = 1'b1;
        if (hold_rvc) begin
          instr         = {16'h0, hold};
          is_compressed = 1'b1;
          pc_incr       = 2'd1;
        end else begin
          instr           = {word[15:0], hold};
          consume_word    = 1'b1;
          next_hold       = word[31:16];
          next_hold_valid = 1'b1;
          pc_incr         = 2'd2;
        end
      end
      (!hold_valid && !pc_half): begin
        valid        = 1'b1;
        consume_word = 1'b1;
        if (lo_rvc) begin
          instr           = {16'h0, word[15:0]};
          is_compressed   = 1'b1;
          next_hold       = word[31:16];
          next_hold_valid = 1'b1;
          pc_incr         = 2'd1;
        end else begin
          instr   = word;
          pc_incr = 2'd2;
        end
      end
      (!hold_valid && pc_half): begin
        consume_word = 1'b1;
        if (hi_rvc) begin
          valid         = 1'b1;
          instr         = {16'h0, word[31:16]};
          is_compressed = 1'b1;
          pc_incr       = 2'd1;
        end else begin
          // upper half starts a 32-bit op: park it, fetch the rest
          next_hold       = word[31:16];
          next_hold_valid = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns PC, drives instr_cache word address, hands decode one
// instruction per cycle over valid/ready; redirect restarts fetch.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 29
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [XLEN-1:0]   mem_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              is_compressed_o,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i
);

  logic [XLEN-1:1]   pc_q;
  logic [ADDR_W-1:0] fetch_q;
  logic [HALF_W-1:0] hold_q;
  logic              hold_valid_q;

  logic [XLEN-1:0]   al_instr;
  logic              al_rvc;
  logic              al_valid;
  logic              al_consume;
  logic [HALF_W-1:0] al_hold;
  logic              al_hold_valid;
  logic [1:0]        al_incr;
  logic              advance;
  logic              unused_pc_bit0;

  assign unused_pc_bit0 = redirect_pc_i[0];

  instr_aligner u_aligner (
    .word            (mem_data_i),
    .hold            (hold_q),
    .hold_valid      (hold_valid_q),
    .pc_half         (pc_q[1]),
    .instr           (al_instr),
    .is_compressed   (al_rvc),
    .valid           (al_valid),
    .consume_word    (al_consume),
    .next_hold       (al_hold),
    .next_hold_valid (al_hold_valid),
    .pc_incr         (al_incr)
  );

  // a bubble advances without a handshake
  assign advance = !al_valid || instr_ready_i;

  assign mem_addr_o      = fetch_q;
  assign pc_o            = {pc_q, 1'b0};
  assign instr_valid_o   = al_valid && !rst_i && !redirect_i;
  assign instr_o         = instr_valid_o ? al_instr : '0;
  assign is_compressed_o = instr_valid_o && al_rvc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC[XLEN-1:1];
      fetch_q      <= RESET_PC[ADDR_W+1:2];
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q         <= redirect_pc_i[XLEN-1:1];
      fetch_q      <= redirect_pc_i[ADDR_W+1:2];
      hold_valid_q <= 1'b0;
    end else if (advance) begin
      pc_q         <= pc_q + {{(XLEN-3){1'b0}}, al_incr};
      fetch_q      <= fetch_q + {{(ADDR_W-1){1'b0}}, al_consume};
      hold_q       <= al_hold;
      hold_valid_q <= al_hold_valid;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instr_cache model.
// Checks reset, compressed/straddle extraction, stall, redirect, wrap.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [28:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        is_compressed_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  logic [31:0] mem [0:15];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  assign mem_data_i = mem[mem_addr_o[3:0]];

  instr_fetch_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mem_addr_o      (mem_addr_o),
    .mem_data_i      (mem_data_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .is_compressed_o (is_compressed_o),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i)
  );

  task automatic chk(input string tag, input logic [65:0] obs,
                     input logic [65:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_instr(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic c);
    chk(tag, {instr_valid_o, pc_o, instr_o, is_compressed_o},
        {1'b1, pc, ins, c});
  endtask

  task automatic exp_none(input string tag);
    chk(tag, {33'h0, instr_valid_o, instr_o},
        {33'h0, 1'b0, 32'h0});
  endtask

  task automatic exp_addr(input string tag, input logic [28:0] a);
    chk(tag, {37'h0, mem_addr_o}, {37'h0, a});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input int t);
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    if (t == 1) begin
      mem[0] = 32'h8000_04b7;
      mem[1] = 32'h452d_4101;
      mem[2] = 32'h2011_45b5;
    end else begin
      mem[0]  = 32'h0013_0001;
      mem[1]  = 32'h4101_0000;
      mem[15] = 32'h4101_0001;
    end
  endtask

  initial begin
    rst_i = 1'b1;
    instr_ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    load(1);
    #1;
    exp_none("rst_valid");
    exp_addr("rst_addr", 29'h0);
    chk("rst_pc", {34'h0, pc_o}, {34'h0, 32'h0});
    #11 rst_i = 1'b0;
    #1;
    exp_instr("t1_pc0", 32'h0, 32'h8000_04b7, 1'b0);
    step(); exp_instr("t1_pc4", 32'h4, 32'h0000_4101, 1'b1);
    step(); exp_instr("t1_pc6", 32'h6, 32'h0000_452d, 1'b1);
    step(); exp_instr("t1_pc8", 32'h8, 32'h0000_45b5, 1'b1);
    step(); exp_instr("t1_pc10", 32'ha, 32'h0000_2011, 1'b1);

    redirect_i = 1'b1;
    redirect_pc_i = 32'h0;
    #1 exp_none("t3_redir_cycle");
    step(); redirect_i = 1'b0;
    #1 exp_instr("t3_pc0", 32'h0, 32'h8000_04b7, 1'b0);
    step(); instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 exp_instr("t3_stall", 32'h4, 32'h0000_4101, 1'b1);
      exp_addr("t3_stall_addr", 29'h1);
      step();
    end
    instr_ready_i = 1'b1;
    #1 exp_instr("t3_hold", 32'h4, 32'h0000_4101, 1'b1);
    step(); exp_instr("t3_resume", 32'h6, 32'h0000_452d, 1'b1);

    redirect_i = 1'b1;
    redirect_pc_i = 32'h8;
    #1 exp_none("t5_no_xfer");
    step(); redirect_i = 1'b0;
    #1 exp_instr("t5_target", 32'h8, 32'h0000_45b5, 1'b1);

    redirect_i = 1'b1;
    redirect_pc_i = 32'h6;
    step(); redirect_i = 1'b0;
    #1 exp_instr("t4_pc6", 32'h6, 32'h0000_452d, 1'b1);
    step(); exp_instr("t4_pc8", 32'h8, 32'h0000_45b5, 1'b1);

    load(2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h2;
    step(); redirect_i = 1'b0;
    #1 exp_none("t4_bubble");
    exp_addr("t4_bubble_addr", 29'h0);
    step(); exp_instr("t4_pc2", 32'h2, 32'h0000_0013, 1'b0);
    step(); exp_instr("t4_pc6b", 32'h6, 32'h0000_4101, 1'b1);

    redirect_i = 1'b1;
    redirect_pc_i = 32'h0;
    step(); redirect_i = 1'b0;
    #1 exp_instr("t2_pc0", 32'h0, 32'h0000_0001, 1'b1);
    step(); exp_instr("t2_pc2", 32'h2, 32'h0000_0013, 1'b0);
    step(); exp_instr("t2_pc6", 32'h6, 32'h0000_4101, 1'b1);

    redirect_i = 1'b1;
    redirect_pc_i = 32'hffff_fffc;
    step(); redirect_i = 1'b0;
    #1 exp_addr("wrap_addr", 29'h1fff_ffff);
    exp_instr("wrap_pcfc", 32'hffff_fffc, 32'h0000_0001, 1'b1);
    step(); exp_instr("wrap_pcfe", 32'hffff_fffe, 32'h0000_4101, 1'b1);
    step(); exp_instr("wrap_pc0", 32'h0, 32'h0000_0001, 1'b1);
    step(); exp_instr("wrap_pc2", 32'h2, 32'h0000_0013, 1'b0);

    rst_i = 1'b1;
    #1 exp_none("t6_rst_now");
    #1 exp_addr("t6_rst_addr", 29'h0);
    chk("t6_rst_pc", {34'h0, pc_o}, {34'h0, 32'h0});
    #1 rst_i = 1'b0;
    #1 exp_instr("t6_after", 32'h0, 32'h0000_0001, 1'b1);
    step(); exp_instr("t6_next", 32'h2, 32'h0000_0013, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
